// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the next-PC sequencer and its return-address stack.
package mips_pc_pkg;

  localparam int unsigned N_BITS      = 32;
  localparam logic [31:0] EXC_VECTOR  = 32'h8000_0180;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_SEQ,
    PC_BRANCH,
    PC_JUMP,
    PC_JR
  } pc_src_e;

  typedef enum logic [0:0] {
    ST_RUN,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: push, pop, or replace-top when both are asserted together.
module return_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  top_q, top_d;
  logic [PtrW:0]    count_q, count_d;
  logic             wr_en;
  logic [PtrW-1:0]  wr_ptr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign top_o   = empty_o ? '0 : mem_q[top_q];

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q;
    if (push_i && pop_i && !empty_o) begin
      wr_en = 1'b1;
    end else if (push_i) begin
      // When full the oldest slot is the one at top+1, so it is overwritten naturally.
      top_d  = top_q + PtrW'(1);
      wr_ptr = top_d;
      wr_en  = 1'b1;
      if (!full_o) count_d = count_q + (PtrW + 1)'(1);
    end else if (pop_i && !empty_o) begin
      top_d   = top_q - PtrW'(1);
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      if (wr_en) mem_q[wr_ptr] <= data_i;
    end
  end

endmodule

// File: rtl/next_pc_sequencer.sv
// Next-PC selection with return-address stack tracking of jal/jr $ra.
// Optional misaligned-target trap enabled by NEXT_PC_ALIGN_TRAP_EN.
module next_pc_sequencer #(
  parameter int unsigned         N_BITS     = mips_pc_pkg::N_BITS,
  parameter int unsigned         RAS_DEPTH  = 4,
  parameter logic [N_BITS-1:0]   EXC_VECTOR = mips_pc_pkg::EXC_VECTOR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BITS-1:0] pc_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [N_BITS-1:0] branch_offset_i,
  input  logic              jump_i,
  input  logic              jal_i,
  input  logic [25:0]       jump_index_i,
  input  logic              jr_i,
  input  logic              jr_is_ra_i,
  input  logic [N_BITS-1:0] jr_target_i,
  output logic [N_BITS-1:0] new_pc_o,
  output logic [N_BITS-1:0] ras_top_o,
  output logic              ras_hit_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              misalign_o,
  output logic [N_BITS-1:0] epc_o
);

  mips_pc_pkg::pc_src_e pc_src;
  mips_pc_pkg::state_e  state_q;
  logic [N_BITS-1:0]    pc_plus4;
  logic [N_BITS-1:0]    target_raw;
  logic                 trap;
  logic                 ras_push, ras_pop;

  assign pc_plus4 = pc_i + N_BITS'(mips_pc_pkg::INSTR_BYTES);

  always_comb begin
    if (stall_i)                pc_src = mips_pc_pkg::PC_HOLD;
    else if (jr_i)              pc_src = mips_pc_pkg::PC_JR;
    else if (jump_i || jal_i)   pc_src = mips_pc_pkg::PC_JUMP;
    else if (branch_i)          pc_src = mips_pc_pkg::PC_BRANCH;
    else                        pc_src = mips_pc_pkg::PC_SEQ;
  end

  always_comb begin
    target_raw = pc_plus4;
    unique case (pc_src)
      mips_pc_pkg::PC_HOLD:   target_raw = pc_i;
      mips_pc_pkg::PC_JR:     target_raw = jr_target_i;
      mips_pc_pkg::PC_JUMP:   target_raw = {pc_plus4[N_BITS-1:28], jump_index_i, 2'b00};
      mips_pc_pkg::PC_BRANCH: target_raw = pc_plus4 + (branch_offset_i << 2);
      default:                target_raw = pc_plus4;
    endcase
  end

`ifdef NEXT_PC_ALIGN_TRAP_EN
  logic [N_BITS-1:0] epc_q;

  assign trap       = (pc_src != mips_pc_pkg::PC_HOLD) && (target_raw[1:0] != 2'b00);
  assign misalign_o = trap;
  assign new_pc_o   = trap ? EXC_VECTOR : target_raw;
  assign epc_o      = epc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    epc_q <= '0;
    else if (trap) epc_q <= target_raw;
  end
`else
  assign trap       = 1'b0;
  assign misalign_o = 1'b0;
  assign new_pc_o   = (pc_src == mips_pc_pkg::PC_HOLD) ? pc_i : (target_raw & ~N_BITS'(3));
  assign epc_o      = '0;
`endif

  // jal with jr on a non-$ra register is neither a push nor a pop.
  assign ras_push = jal_i && (!jr_i || jr_is_ra_i) && !stall_i && !trap;
  assign ras_pop  = jr_i && jr_is_ra_i && !stall_i && !trap;

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (N_BITS)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_plus4),
    .top_o   (ras_top_o),
    .empty_o (ras_empty_o),
    .full_o  (ras_full_o)
  );

  assign ras_hit_o = jr_i && jr_is_ra_i && !ras_empty_o && (ras_top_o == jr_target_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= mips_pc_pkg::ST_RUN;
    end else begin
      unique case (state_q)
        mips_pc_pkg::ST_RUN:  if (stall_i)  state_q <= mips_pc_pkg::ST_HOLD;
        mips_pc_pkg::ST_HOLD: if (!stall_i) state_q <= mips_pc_pkg::ST_RUN;
        default:              state_q <= mips_pc_pkg::ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_sequencer.sv
// Directed plus randomized bench for next_pc_sequencer against a queue-based reference model.
module tb_next_pc_sequencer;

  localparam int unsigned Depth  = 4;
  localparam logic [31:0] ExcVec = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_i, branch_offset_i, jr_target_i;
  logic        stall_i, branch_i, jump_i, jal_i, jr_i, jr_is_ra_i;
  logic [25:0] jump_index_i;
  logic [31:0] new_pc_o, ras_top_o, epc_o;
  logic        ras_hit_o, ras_empty_o, ras_full_o, misalign_o;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ras_m[$];
  logic [31:0] epc_m;

  next_pc_sequencer #(
    .N_BITS     (32),
    .RAS_DEPTH  (Depth),
    .EXC_VECTOR (ExcVec)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pc_i            (pc_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_offset_i (branch_offset_i),
    .jump_i          (jump_i),
    .jal_i           (jal_i),
    .jump_index_i    (jump_index_i),
    .jr_i            (jr_i),
    .jr_is_ra_i      (jr_is_ra_i),
    .jr_target_i     (jr_target_i),
    .new_pc_o        (new_pc_o),
    .ras_top_o       (ras_top_o),
    .ras_hit_o       (ras_hit_o),
    .ras_empty_o     (ras_empty_o),
    .ras_full_o      (ras_full_o),
    .misalign_o      (misalign_o),
    .epc_o           (epc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic st, input logic br,
                       input logic [31:0] off, input logic j, input logic jl,
                       input logic [25:0] idx, input logic jr, input logic ra,
                       input logic [31:0] jrt);
    pc_i = pc; stall_i = st; branch_i = br; branch_offset_i = off; jump_i = j;
    jal_i = jl; jump_index_i = idx; jr_i = jr; jr_is_ra_i = ra; jr_target_i = jrt;
  endtask

  task automatic idle(input logic [31:0] pc);
    drive(pc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Checks all outputs against the model, clocks once, then advances the model.
  task automatic tick(input string tag);
    logic [31:0] pc4, tgt, exp_pc, top_m;
    logic        mis, hit_m;
    #2;
    pc4 = pc_i + 32'd4;
    if (stall_i)              tgt = pc_i;
    else if (jr_i)            tgt = jr_target_i;
    else if (jump_i || jal_i) tgt = (pc4 & 32'hF000_0000) | (32'(jump_index_i) * 4);
    else if (branch_i)        tgt = pc4 + branch_offset_i * 4;
    else                      tgt = pc4;
`ifdef NEXT_PC_ALIGN_TRAP_EN
    mis    = !stall_i && (tgt % 4 != 0);
    exp_pc = mis ? ExcVec : tgt;
`else
    mis    = 1'b0;
    exp_pc = stall_i ? tgt : tgt - (tgt % 4);
`endif
    top_m = (ras_m.size() > 0) ? ras_m[ras_m.size()-1] : 32'h0;
    hit_m = jr_i && jr_is_ra_i && (ras_m.size() > 0) && (top_m == jr_target_i);
    check({tag, "/new_pc"}, new_pc_o, exp_pc);
    check({tag, "/ras_top"}, ras_top_o, top_m);
    check({tag, "/ras_hit"}, 32'(ras_hit_o), 32'(hit_m));
    check({tag, "/ras_empty"}, 32'(ras_empty_o), 32'(ras_m.size() == 0));
    check({tag, "/ras_full"}, 32'(ras_full_o), 32'(ras_m.size() == Depth));
    check({tag, "/misalign"}, 32'(misalign_o), 32'(mis));
    check({tag, "/epc"}, epc_o, epc_m);
    @(posedge clk);
    #1;
    if (!stall_i && !mis) begin
      if (jal_i && jr_i && jr_is_ra_i) begin
        if (ras_m.size() > 0) ras_m[ras_m.size()-1] = pc4;
        else ras_m.push_back(pc4);
      end else if (jal_i && !jr_i) begin
        ras_m.push_back(pc4);
        if (ras_m.size() > Depth) void'(ras_m.pop_front());
      end else if (jr_i && jr_is_ra_i && !jal_i) begin
        if (ras_m.size() > 0) void'(ras_m.pop_back());
      end
    end
    if (mis) epc_m = tgt;
  endtask

  initial begin
    logic [31:0] rpc, rjrt;
    ras_m.delete();
    epc_m = 32'h0;
    reset = 1'b0;
    idle(32'h0040_0000);
    #12;
    check("reset/empty", 32'(ras_empty_o), 32'd1);
    check("reset/top", ras_top_o, 32'h0);
    check("reset/full", 32'(ras_full_o), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick("t1_seq");

    drive(32'h0040_0010, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    tick("t2_branch");
    drive(32'h0040_0010, 1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
    tick("t2_stall");

    drive(32'h0040_0020, 0, 0, 0, 0, 1, 26'h010_0040, 0, 0, 0);
    #1 check("t3_jal_pc", new_pc_o, 32'h0040_0100);
    tick("t3_jal");
    check("t3_top", ras_top_o, 32'h0040_0024);
    drive(32'h0040_0100, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0024);
    #1 check("t3_hit", 32'(ras_hit_o), 32'd1);
    tick("t3_jr");
    check("t3_empty", 32'(ras_empty_o), 32'd1);

    for (int i = 1; i <= 5; i++) begin
      drive(32'(i * 16), 0, 0, 0, 0, 1, 26'h40, 0, 0, 0);
      tick("t4_push");
    end
    check("t4_full", 32'(ras_full_o), 32'd1);
    check("t4_top", ras_top_o, 32'h54);
    for (int i = 0; i < 5; i++) begin
      drive(32'h100, 0, 0, 0, 0, 0, 0, 1, 1, 32'h54 - 32'(i * 16));
      tick("t4_pop");
    end
    check("t4_empty", 32'(ras_empty_o), 32'd1);

    idle(32'hFFFF_FFFC);
    #1 check("t5_wrap", new_pc_o, 32'h0);
    tick("t5_wrap");
    drive(32'h0000_1000, 0, 0, 0, 0, 1, 26'h80, 0, 0, 0);
    tick("t5_push");
    drive(32'h0000_2000, 0, 0, 0, 0, 1, 26'h80, 1, 1, 32'h0000_1004);
    tick("t5_jalr");
    check("t5_top", ras_top_o, 32'h0000_2004);

    drive(32'h0000_3000, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0040_0102);
`ifdef NEXT_PC_ALIGN_TRAP_EN
    #1 check("t6_vec", new_pc_o, 32'h8000_0180);
    tick("t6_trap");
    check("t6_epc", epc_o, 32'h0040_0102);
`else
    #1 check("t6_forced", new_pc_o, 32'h0040_0100);
    tick("t6_forced");
`endif

    // Async reset in the middle of a push cycle must clear the stack at once.
    drive(32'h0000_4000, 0, 0, 0, 0, 1, 26'h10, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check("rst_mid/empty", 32'(ras_empty_o), 32'd1);
    check("rst_mid/top", ras_top_o, 32'h0);
    check("rst_mid/epc", epc_o, 32'h0);
    ras_m.delete();
    epc_m = 32'h0;
    @(posedge clk); #1;
    reset = 1'b1;
    tick("rst_after");

    for (int n = 0; n < 600; n++) begin
      rpc = $urandom;
      if ($urandom_range(0, 15) != 0) rpc[1:0] = 2'b00;
      if (ras_m.size() > 0 && $urandom_range(0, 1) == 1) rjrt = ras_m[ras_m.size()-1];
      else rjrt = $urandom;
      if (rjrt[1:0] != 2'b00 && $urandom_range(0, 3) != 0) rjrt[1:0] = 2'b00;
      drive(rpc, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, 26'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, rjrt);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
